// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr_if
// Description : Bundle of the stream_mux_rr channel, control and output
//               signals. The "master" modport is the side that drives the
//               input channels and the output-side ready. The "slave" modport
//               is the multiplexer itself.
//   in_data   : NUM_IN*DATA_W packed words, channel i at [i*DATA_W +: DATA_W]
//   in_valid  : per-channel valid
//   in_ready  : per-channel accept, driven by the mux
//   sel, mode : fixed-select index and mode (0 fixed, 1 round-robin)
//   out_*     : registered output stream and source index
//   xfer_cnt  : accepted-input counter (zero unless the counter is built)
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_mux_rr_if #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [SEL_W-1:0]         sel;
  logic                     mode;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [SEL_W-1:0]         out_src;
  logic [31:0]              xfer_cnt;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, out_src, xfer_cnt
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, out_src, xfer_cnt
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : NUM_IN-to-1 registered stream multiplexer with valid/ready
//               handshakes. mode=0 grants the channel named by sel; mode=1
//               arbitrates round-robin starting after the last granted
//               channel. The output is a one-entry register that can drain
//               and refill in the same cycle, so throughput is one word/cycle.
// Ports       :
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - stream_mux_rr_if.slave (channels, sel/mode, output, xfer_cnt)
// Parameters  : DATA_W (word width), NUM_IN (2..16 channels)
// Options     : define STREAM_MUX_XFER_CNT_EN to build the 32-bit wrapping
//               accepted-input counter on xfer_cnt; otherwise xfer_cnt is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4
) (
  input  logic           clk,
  input  logic           rst,
  stream_mux_rr_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  // NUM_IN one bit wider than sel so out-of-range selects can be detected.
  localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  // Unpacked view of the channel words
  logic [DATA_W-1:0] ch_data [NUM_IN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign ch_data[gi] = bus.in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // State
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_src_q,   out_src_d;
  logic [SEL_W-1:0]  rr_last_q,   rr_last_d;

  // Arbitration
  logic              load_en;
  logic              sel_in_range;
  logic              fix_grant;
  logic              rr_hi_found;
  logic              rr_any_found;
  logic [SEL_W-1:0]  rr_hi_idx;
  logic [SEL_W-1:0]  rr_any_idx;
  logic [SEL_W-1:0]  rr_idx;
  logic              grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_IN-1:0] in_ready_w;

  assign load_en      = !out_valid_q || bus.out_ready;
  assign sel_in_range = ({1'b0, bus.sel} < NUM_IN_EXT);
  assign fix_grant    = sel_in_range && bus.in_valid[bus.sel];

  // Round-robin scan split into two priority searches: the lowest valid
  // channel above rr_last, falling back to the lowest valid channel overall
  // (the wrap-around case). The descending loop leaves the lowest match.
  always_comb begin
    rr_hi_found  = 1'b0;
    rr_any_found = 1'b0;
    rr_hi_idx    = '0;
    rr_any_idx   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        rr_any_found = 1'b1;
        rr_any_idx   = SEL_W'(i);
        if (SEL_W'(i) > rr_last_q) begin
          rr_hi_found = 1'b1;
          rr_hi_idx   = SEL_W'(i);
        end
      end
    end
  end

  assign rr_idx    = rr_hi_found ? rr_hi_idx : rr_any_idx;
  assign grant     = !rst && load_en && (bus.mode ? rr_any_found : fix_grant);
  assign grant_idx = bus.mode ? rr_idx : bus.sel;

  always_comb begin
    in_ready_w = '0;
    if (grant) begin
      in_ready_w[grant_idx] = 1'b1;
    end
  end

  // Next-state for the output register and round-robin pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_last_d   = rr_last_q;
    if (load_en) begin
      // A load slot with nothing granted empties the buffer but keeps the
      // last word/source visible on the data lines.
      out_valid_d = grant;
      if (grant) begin
        out_data_d = ch_data[grant_idx];
        out_src_d  = grant_idx;
        if (bus.mode) begin
          rr_last_d = grant_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_last_q   <= LAST_IDX;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef STREAM_MUX_XFER_CNT_EN
  // A grant always pairs in_ready with in_valid, so it marks an acceptance.
  logic [31:0] xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= 32'h0;
    end else if (grant) begin
      xfer_cnt_q <= xfer_cnt_q + 32'h1;
    end
  end

  assign bus.xfer_cnt = xfer_cnt_q;
`else
  assign bus.xfer_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-to-1 registered stream multiplexer for the datapath, successor to the plain 2-to-1 mux.
- Each input channel and the output use a valid/ready handshake.
- Two modes: fixed select (S-driven, like the combinational mux) and round-robin arbitration across all channels.
- Output is registered: one-entry buffer, full throughput. Sits between pipeline producers (e.g. writeback sources) and a shared consumer.

Parameters:
- DATA_W, 32, width of each data word.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, derived localparam = clog2(NUM_IN); not overridable.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_IN  channel i has a word.
- in_ready  out  NUM_IN  channel i word accepted this cycle.
- sel  in  SEL_W  channel index used in fixed mode.
- mode  in  1  0 = fixed select, 1 = round-robin.
- out_data  out  DATA_W  registered output word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_src  out  SEL_W  channel index that produced out_data.
- xfer_cnt  out  32  accepted-input count (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_src=0, rr_last=NUM_IN-1 (channel 0 has first priority), xfer_cnt=0.
- in_ready is combinational from state and inputs. It is 0 for all channels while rst=1.
- load_en = !out_valid || out_ready. Arbitration happens only when load_en=1.
- Fixed mode (mode=0):
  - Grant channel sel if in_valid[sel]=1.
  - No grant if sel >= NUM_IN.
  - No grant if in_valid[sel]=0, even if other channels are valid.
- Round-robin mode (mode=1):
  - Scan channels rr_last+1, rr_last+2, ... modulo NUM_IN.
  - Grant the first channel with in_valid=1.
  - On a grant, rr_last <= granted index. With no grant, rr_last is unchanged.
  - rr_last is not updated in fixed mode.
- Grant to channel g:
  - in_ready[g]=1 and all other in_ready bits are 0.
  - At the next edge: out_data <= in_data[g], out_src <= g, out_valid <= 1.
- load_en=1 with no grant: out_valid <= 0 at the edge; out_data and out_src hold their old values.
- load_en=0 (out_valid=1, out_ready=0): out_data, out_src and out_valid hold; all in_ready are 0.
- Latency: an input accepted at edge k appears on out_data after edge k. Sustained one word/cycle when out_ready=1.
- Simultaneous output drain and refill in the same cycle is allowed; no bubble is inserted.
- Mode or sel changes take effect at the next arbitration. The word already in the output register is never dropped or altered.
- Reset mid-transfer: the buffered word is discarded and out_valid=0 the next cycle.
- in_valid bits on non-granted channels are not consumed. Inputs are expected to hold their data until ready.

Optional Feature:
- Macro: STREAM_MUX_XFER_CNT_EN.
- Defined:
  - xfer_cnt increments by 1 on every edge where any in_ready=1 with its in_valid=1.
  - It wraps from 32'hFFFFFFFF to 0.
  - It is cleared by rst.
- Undefined: xfer_cnt is tied to 32'h0 and no counter logic is generated.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0; after release, first grant goes to channel 0.
- Fixed mode: mode=0, sel=1, in_data ch0=32'hABCDEFF1, ch1=32'h76543210, all valid, out_ready=1 -> next cycle out_data=32'h76543210, out_src=1. Then sel=0 -> next cycle 32'hABCDEFF1.
- Fixed mode, invalid select: mode=0, sel=2, in_valid=4'b1011 -> no in_ready asserted, out_valid falls to 0 after one cycle.
- Round-robin fairness: mode=1, all 4 valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, one word per cycle.
- Round-robin skipping: only ch2 and ch3 valid -> out_src alternates 2,3,2,3.
- Backpressure: out_ready=0 for 3 cycles while a word (32'h9ABCDEFF) is buffered -> out_data stable, in_ready=0, rr_last unchanged. On out_ready=1 the next word loads in the same cycle.
- Counter (macro defined): 5 accepted transfers -> xfer_cnt=5. Counter preset path near 32'hFFFFFFFF wraps to 0. With the macro undefined, xfer_cnt reads 0 throughout.
